// File: rtl/aes_pkg.sv
// Shared types and constants for the AES SPI front end.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    START     = 3'd2,
    WAIT      = 3'd3,
    SHIFT_OUT = 3'd4
  } state_t;

  localparam logic [7:0] DIR_ENC = 8'h00;
  localparam logic [7:0] DIR_DEC = 8'hFF;

  // Frame length: optional direction byte, 128-bit message, K-bit key.
  function automatic int frame_bits(input int k, input int inv);
    return (inv == 2) ? (k + 136) : (k + 128);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser with rise/fall pulses, one bit lane per input.
module spi_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta;
  logic [W-1:0] sync;
  logic [W-1:0] prev;

  // Synchroniser chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/aes_spi_frontend.sv
// SPI slave front end: deserialises {dir, message, key}, starts the AES
// core once per good frame and shifts the core result back out on sdo.
module aes_spi_frontend
  import aes_pkg::*;
#(
  parameter int K   = 128,
  parameter int INV = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sck,
  input  logic           sdi,
  input  logic           load,
  output logic           sdo,
  output logic           done,
  output logic           frame_err,
  output logic           core_start,
  output logic           core_decrypt,
  output logic [K-1:0]   core_key,
  output logic [127:0]   core_block,
  input  logic           core_done,
  input  logic [127:0]   core_result
);

  localparam int TOTAL = frame_bits(K, INV);
  localparam int CW    = $clog2(TOTAL + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TOTAL + 1);

  logic [2:0]       sync_level;
  logic [2:0]       sync_rise;
  logic [2:0]       sync_fall;
  logic             sck_rise;
  logic             sck_fall;
  logic             load_level;
  logic             load_rise;
  logic             load_fall;
  logic             sdi_s;
  logic             unused_sync;

  state_t           state_q;
  state_t           state_d;
  logic [TOTAL-1:0] shift_q;
  logic [TOTAL-1:0] shift_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             take_bit;
  logic             frame_ok;
  logic             dir_dec;
  logic [127:0]     out_q;

  spi_sync #(.W(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   ({sck, load, sdi}),
    .level (sync_level),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  assign sck_rise    = sync_rise[2];
  assign sck_fall    = sync_fall[2];
  assign load_level  = sync_level[1];
  assign load_rise   = sync_rise[1];
  assign load_fall   = sync_fall[1];
  assign sdi_s       = sync_level[0];
  assign unused_sync = ^{sync_level[2], sync_rise[0], sync_fall[0]};

  // Incoming bit path; a bit arriving with the load falling edge still counts.
  always_comb begin
    take_bit = (state_q == SHIFT_IN) && sck_rise && (load_level || load_fall);
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    if (take_bit) begin
      shift_d = {shift_q[TOTAL-2:0], sdi_s};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    end
    frame_ok = (cnt_d == CNT_FULL);
    if (INV == 0)      dir_dec = 1'b0;
    else if (INV == 1) dir_dec = 1'b1;
    else               dir_dec = (shift_d[TOTAL-1 -: 8] != DIR_ENC);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (load_rise) state_d = SHIFT_IN;
      SHIFT_IN:  if (load_fall) state_d = frame_ok ? START : IDLE;
      START:     state_d = WAIT;
      WAIT:      if (load_rise) state_d = SHIFT_IN;
                 else if (core_done) state_d = SHIFT_OUT;
      SHIFT_OUT: if (load_rise) state_d = SHIFT_IN;
      default:   state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Frame capture, core operand latch, status flags and output shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      out_q        <= '0;
      done         <= 1'b0;
      frame_err    <= 1'b0;
      core_key     <= '0;
      core_block   <= '0;
      core_decrypt <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      if (state_d == SHIFT_IN && state_q != SHIFT_IN) begin
        cnt_q     <= '0;
        out_q     <= '0;
        done      <= 1'b0;
        frame_err <= 1'b0;
      end
      if (state_q == SHIFT_IN && load_fall) begin
        if (frame_ok) begin
          core_key     <= shift_d[K-1:0];
          core_block   <= shift_d[K+127:K];
          core_decrypt <= dir_dec;
        end else begin
          frame_err <= 1'b1;
        end
      end
      if (state_q == WAIT && core_done && !load_rise) begin
        out_q <= core_result;
        done  <= 1'b1;
      end
      if (state_q == SHIFT_OUT && sck_fall && !load_rise) begin
        out_q <= {out_q[126:0], 1'b0};
      end
    end
  end

  assign core_start = (state_q == START);
  assign sdo        = out_q[127];

endmodule

// File: doc/aes_spi_frontend.md
Name: aes_spi_frontend

Overview:
- SPI slave front end that sits directly upstream of the AES core and feeds it.
- Deserialises the load-framed input stream (optional direction byte, message, key) in the clk domain and issues one start pulse to the core.
- Captures the 128-bit core result and serialises it back out on sdo, with done as the host-visible status.

Parameters:
K, 128, key width in bits (128, 192 or 256).
INV, 2, direction mode: 0 = encrypt only, 1 = decrypt only, 2 = runtime-selectable via leading direction byte.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
sck  in  1  SPI clock from host, asynchronous to clk.
sdi  in  1  SPI serial data in, MSB first.
load  in  1  host frame strobe, asynchronous; high while shifting in.
sdo  out  1  SPI serial data out, MSB first.
done  out  1  result ready for shift-out.
frame_err  out  1  last frame had the wrong bit count.
core_start  out  1  one-cycle start pulse to AES core.
core_decrypt  out  1  1 = decrypt, 0 = encrypt; valid while core_start is high.
core_key  out  K  key to core.
core_block  out  128  message block to core.
core_done  in  1  one-cycle pulse from core when the result is valid.
core_result  in  128  core output block; sampled when core_done is high.

Behaviour:
- Fixed facts:
  - Single clock clk.
  - rst_n is asynchronous and active-low.
  - sck, sdi and load each pass through a 2-flop synchroniser.
  - Rising and falling edges of sck and load are detected on the synchronised signals.
  - Host sck high and low phases must each be at least 3 clk periods.
- Frame length: TOTAL = K+128 when INV != 2, otherwise K+136. The frame is {dir_byte, message, key}, MSB first.
- States:
  - IDLE: wait for load rising -> SHIFT_IN. Clear bit counter, done and frame_err.
  - SHIFT_IN: on each sck rising while load is high, shift sdi into LSB of a TOTAL-bit register and increment bit counter. The counter saturates at TOTAL+1; further bits keep shifting. On load falling:
    - count == TOTAL -> START.
    - otherwise -> IDLE with frame_err = 1 (held until next load rising).
  - START: hold 1 cycle with core_start = 1 -> WAIT. core_key = low K bits; core_block = next 128 bits.
  - WAIT: on core_done, load core_result into the 128-bit output shift register, set done = 1 -> SHIFT_OUT.
  - SHIFT_OUT: sdo = out_reg[127]. On each sck falling edge, shift left and fill 0. After 128 shifts sdo = 0. Stay here until load rising -> SHIFT_IN, which clears done.
- Direction:
  - INV = 0: core_decrypt = 0.
  - INV = 1: core_decrypt = 1.
  - INV = 2: core_decrypt = (dir_byte != 8'h00).
- core_key, core_block and core_decrypt are held stable from START until the next frame completes.
- Reset values: sdo = 0, done = 0, frame_err = 0, core_start = 0, core_decrypt = 0, core_key = 0, core_block = 0. State = IDLE, counters = 0.
- Latency: core_start is asserted 1 cycle after the synchronised load falling edge. done is asserted 1 cycle after core_done.
- Boundary conditions:
  - load rising during WAIT or SHIFT_OUT aborts to SHIFT_IN. A later core_done is ignored.
  - core_done outside WAIT is ignored.
  - sck edges while load is low in SHIFT_IN, or in IDLE, START or WAIT, are ignored.
  - Simultaneous sck rising and load falling: the bit is shifted first, then the count is checked.
  - rst_n asserted mid-frame or mid-shift-out returns all outputs to reset values immediately.

Decomposition:
- aes_pkg holds:
  - the state enum (IDLE, SHIFT_IN, START, WAIT, SHIFT_OUT);
  - function frame_bits(K, INV) returning TOTAL;
  - the direction encoding constants DIR_ENC = 8'h00 and DIR_DEC = 8'hFF.
- Sub-module spi_sync: parameterised-width 2-flop synchroniser with rise/fall pulse outputs. Instantiated once for {sck, load, sdi}.

Test Plan:
1. K = 128, INV = 2, dir 8'h00, plaintext 3243F6A8885A308D313198A2E0370734, key 2B7E151628AED2A6ABF7158809CF4F3C; behavioural core returns 3925841D02DC09FBDC118597196A0B32 -> core_start once with core_decrypt = 0, matching key and block; done = 1; 128 sdo bits equal the ciphertext.
2. Same key, dir 8'hFF, block 3925841D02DC09FBDC118597196A0B32 -> core_decrypt = 1; shifted-out result 3243F6A8885A308D313198A2E0370734.
3. K = 256, INV = 0, key 000102…1F, block 00112233445566778899AABBCCDDEEFF -> TOTAL = 384; core_decrypt = 0; core sees exact vectors; output 8EA2B7CA516745BFEAFC49904B496089.
4. Frame of TOTAL-1 bits, then a frame of TOTAL+5 bits -> no core_start in either case; frame_err = 1; done stays 0.
5. load rising after 40 output bits, then a new full frame -> done drops; second result is shifted out correctly; a stale core_done pulse injected during SHIFT_IN has no effect.
6. rst_n asserted in WAIT, then core_done pulses -> outputs stay at reset values; state IDLE; done = 0.
